// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester.
// Takes read/write commands on a valid/ready port and runs each as a
// SETUP + ACCESS transfer. Returns one response pulse per transfer.
// Optional build macro APB_MASTER_TIMEOUT_EN adds an ACCESS wait counter.
// When the counter reaches TIMEOUT_CYC the transfer is aborted with rsp_err_o.
// Without the macro, ACCESS waits indefinitely and rsp_err_o is tied low.
module apb_master #(
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_write_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_wdata_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              psel_o,
   output logic              penable_o,
   output logic              pwrite_o,
   output logic [ADDR_W-1:0] paddr_o,
   output logic [DATA_W-1:0] pwdata_o,
   input  logic [DATA_W-1:0] prdata_i,
   input  logic              pready_i
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_e;

   state_e              state_q,     state_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic                psel_q,      psel_d;
   logic                penable_q,   penable_d;
   logic                pwrite_q,    pwrite_d;
   logic [ADDR_W-1:0]   paddr_q,     paddr_d;
   logic [DATA_W-1:0]   pwdata_q,    pwdata_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

   logic                rsp_err_q,   rsp_err_d;
   logic [7:0]          wait_cnt_q,  wait_cnt_d;
`endif

   // State and every registered output; all clear asynchronously on reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
         rsp_err_q   <= 1'b0;
         wait_cnt_q  <= 8'd0;
`endif
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
         rsp_err_q   <= rsp_err_d;
         wait_cnt_q  <= wait_cnt_d;
`endif
      end
   end

   // Next-state and next-output logic; outputs are computed one cycle ahead
   // so that everything leaving the block comes straight from a flop.
   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_err_d   = 1'b0;
      wait_cnt_d  = wait_cnt_q;
`endif

      unique case (state_q)
         IDLE: begin
            cmd_ready_d = 1'b1;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            // Accept only when ready is already visible outside.
            // The first cycle after reset therefore never accepts.
            if (cmd_valid_i && cmd_ready_q) begin
               pwrite_d    = cmd_write_i;
               paddr_d     = cmd_addr_i;
               if (cmd_write_i) begin
                  pwdata_d = cmd_wdata_i;
               end
               cmd_ready_d = 1'b0;
               psel_d      = 1'b1;
               state_d     = SETUP;
            end
         end

         SETUP: begin
            psel_d    = 1'b1;
            penable_d = 1'b1;
            state_d   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_d = 8'd0;
`endif
         end

         ACCESS: begin
            if (pready_i) begin
               if (!pwrite_q) begin
                  rsp_rdata_d = prdata_i;
               end
               rsp_valid_d = 1'b1;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = IDLE;
            end
`ifdef APB_MASTER_TIMEOUT_EN
            else if (wait_cnt_q == TIMEOUT_LIM) begin
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
`endif
         end

         default: begin
            state_d     = IDLE;
            cmd_ready_d = 1'b0;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
         end
      endcase
   end

   assign cmd_ready_o = cmd_ready_q;
   assign psel_o      = psel_q;
   assign penable_o   = penable_q;
   assign pwrite_o    = pwrite_q;
   assign paddr_o     = paddr_q;
   assign pwdata_o    = pwdata_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
   assign rsp_err_o   = rsp_err_q;
`else
   assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master with a simple APB register-file slave.
module tb_apb_master;
   localparam int ADDR_W      = 4;
   localparam int DATA_W      = 32;
   localparam int TIMEOUT_CYC = 15;
`ifdef APB_MASTER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              cmd_valid_i = 1'b0;
   logic              cmd_ready_o;
   logic              cmd_write_i = 1'b0;
   logic [ADDR_W-1:0] cmd_addr_i  = '0;
   logic [DATA_W-1:0] cmd_wdata_i = '0;
   logic              rsp_valid_o;
   logic [DATA_W-1:0] rsp_rdata_o;
   logic              rsp_err_o;
   logic              psel_o, penable_o, pwrite_o;
   logic [ADDR_W-1:0] paddr_o;
   logic [DATA_W-1:0] pwdata_o;
   logic [DATA_W-1:0] prdata_i;
   logic              pready_i;

   always #5 clk = ~clk;

   apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
      .paddr_o(paddr_o), .pwdata_o(pwdata_o),
      .prdata_i(prdata_i), .pready_i(pready_i)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rsp_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- APB slave: 16-entry register file ----------------
   logic [DATA_W-1:0] smem [16];
   int acc_cnt = 0;
   int wait_n  = 0;
   bit stuck   = 1'b0;
   bit noise   = 1'b0;

   always @(posedge clk) begin
      if (psel_o && penable_o && !pready_i) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
      if (psel_o && penable_o && pready_i && pwrite_o) smem[paddr_o] <= pwdata_o;
   end
   always @(negedge clk) noise <= 1'($urandom_range(0, 1));
   assign pready_i = (psel_o && penable_o) ? (!stuck && (acc_cnt >= wait_n)) : noise;
   assign prdata_i = smem[paddr_o];

   // ---------------- reference model + scoreboard ----------------
   typedef struct {
      bit          w;
      logic [3:0]  addr;
      logic [31:0] pwdata;
      logic [31:0] rdata;
      bit          err;
      int          acc;
      int          lat;
   } exp_t;
   exp_t q[$];

   logic [31:0] mmem [16];
   logic [31:0] m_rdata  = '0;
   logic [31:0] m_pwdata = '0;

   function automatic void model_reset();
      m_rdata  = '0;
      m_pwdata = '0;
   endfunction

   function automatic exp_t model_cmd(input bit w, input logic [3:0] a,
                                      input logic [31:0] d, input int waits,
                                      input bit stk, input int acc);
      exp_t e;
      e.w = w; e.addr = a; e.acc = acc;
      if (w) m_pwdata = d;
      e.pwdata = m_pwdata;
      if (stk && TO_EN) begin
         m_rdata = '0;
         e.err   = 1'b1;
         e.lat   = 3 + TIMEOUT_CYC;
      end else begin
         e.err = 1'b0;
         e.lat = 3 + waits;
         if (w) mmem[a] = d;
         else   m_rdata = mmem[a];
      end
      e.rdata = m_rdata;
      return e;
   endfunction

   // Monitor: protocol checks on every APB cycle, pops on each response.
   exp_t mon_e;
   bit   prev_rv = 1'b0;
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         prev_rv = 1'b0;
      end else begin
         if (psel_o) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL psel_unexpected: got psel 1 expected no transfer (cycle %0d)", cyc);
            end else begin
               chk("penable_phase", 32'(penable_o), (cyc == q[0].acc + 1) ? 32'd0 : 32'd1);
               chk("paddr", 32'(paddr_o), 32'(q[0].addr));
               chk("pwrite", 32'(pwrite_o), 32'(q[0].w));
               chk("pwdata", pwdata_o, q[0].pwdata);
               chk("ready_busy", 32'(cmd_ready_o), 32'd0);
            end
         end
         if (rsp_valid_o) begin
            rsp_cnt++;
            chk("rsp_single_pulse", 32'(prev_rv), 32'd0);
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rsp_unexpected: got rsp_valid 1 expected 0 (cycle %0d)", cyc);
            end else begin
               mon_e = q.pop_front();
               chk("rsp_rdata", rsp_rdata_o, mon_e.rdata);
               chk("rsp_err", 32'(rsp_err_o), 32'(mon_e.err));
               chk("rsp_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
            end
         end
         prev_rv = rsp_valid_o;
      end
   end

   // ---------------- driver ----------------
   // Called at a negedge; presents the command until accepted, keeps valid high.
   task automatic issue(input bit w, input logic [3:0] a, input logic [31:0] d,
                        input int waits, input bit stk);
      int t;
      cmd_valid_i = 1'b1;
      cmd_write_i = w;
      cmd_addr_i  = a;
      cmd_wdata_i = d;
      t = 0;
      while (cmd_ready_o !== 1'b1 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) begin
         checks++; errors++;
         $display("FAIL accept_timeout: got cmd_ready %b expected 1", cmd_ready_o);
         cmd_valid_i = 1'b0;
         return;
      end
      wait_n = waits;
      stuck  = stk;
      q.push_back(model_cmd(w, a, d, waits, stk, cyc));
      @(negedge clk);
      // junk on the command bus while the transfer runs must be ignored
      cmd_write_i = 1'($urandom_range(0, 1));
      cmd_addr_i  = 4'($urandom);
      cmd_wdata_i = $urandom;
   endtask

   task automatic drain();
      int t;
      cmd_valid_i = 1'b0;
      t = 0;
      while (q.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
         q.delete();
      end
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready_o), 32'd0);
      chk({tag, "_psel"},      32'(psel_o),      32'd0);
      chk({tag, "_penable"},   32'(penable_o),   32'd0);
      chk({tag, "_pwrite"},    32'(pwrite_o),    32'd0);
      chk({tag, "_paddr"},     32'(paddr_o),     32'd0);
      chk({tag, "_pwdata"},    pwdata_o,         32'd0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
      chk({tag, "_rsp_rdata"}, rsp_rdata_o,      32'd0);
      chk({tag, "_rsp_err"},   32'(rsp_err_o),   32'd0);
   endtask

   logic [3:0] addrs [16];
   int base;
   int t;
   int psel_hi;

   initial begin
      for (int i = 0; i < 16; i++) begin
         smem[i] = $urandom;
         mmem[i] = smem[i];
      end

      // reset values
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_reset_outputs("reset");
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("ready_at_release", 32'(cmd_ready_o), 32'd0);
      @(negedge clk);
      chk("ready_after_release", 32'(cmd_ready_o), 32'd1);

      // zero-wait write, then wait-state read
      issue(1'b1, 4'h5, 32'hDEADBEEF, 0, 1'b0);
      drain();
      issue(1'b1, 4'hA, 32'h12345678, 0, 1'b0);
      issue(1'b0, 4'hA, 32'h0, 3, 1'b0);
      drain();

      // back-to-back: 16 writes then 16 reads of the same addresses
      base = rsp_cnt;
      for (int i = 0; i < 16; i++) begin
         addrs[i] = 4'($urandom);
         issue(1'b1, addrs[i], $urandom, 0, 1'b0);
      end
      for (int i = 0; i < 16; i++) issue(1'b0, addrs[i], 32'h0, 0, 1'b0);
      drain();
      chk("b2b_rsp_count", 32'(rsp_cnt - base), 32'd32);

      // random mix with wait states and idle gaps
      for (int i = 0; i < 40; i++) begin
         issue(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom_range(0, 4), 1'b0);
         if ($urandom_range(0, 3) == 0) begin
            cmd_valid_i = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
      end
      drain();

      if (TO_EN) begin
         // abort on stuck slave; pready on the limit edge still completes
         issue(1'b0, 4'h3, 32'h0, 0, 1'b1);
         drain();
         stuck = 1'b0;
         issue(1'b0, 4'h3, 32'h0, TIMEOUT_CYC, 1'b0);
         issue(1'b1, 4'h7, 32'hA5A5_0F0F, TIMEOUT_CYC - 1, 1'b0);
         issue(1'b0, 4'h7, 32'h0, 0, 1'b0);
         drain();
      end else begin
         // stuck slave: transfer hangs in ACCESS
         issue(1'b0, 4'h3, 32'h0, 0, 1'b1);
         cmd_valid_i = 1'b0;
         psel_hi = 0;
         for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            if (psel_o) psel_hi++;
         end
         chk("stuck_psel_cycles", 32'(psel_hi), 32'd110);
         rst = 1'b0;
         #1 q.delete();
         model_reset();
         stuck = 1'b0;
         @(negedge clk);
         #2 rst = 1'b1;
         @(negedge clk);
      end

      // reset during ACCESS
      issue(1'b0, 4'h9, 32'h0, 0, 1'b1);
      cmd_valid_i = 1'b0;
      t = 0;
      while (!(psel_o && penable_o) && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("mid_reset_reached_access", 32'(psel_o && penable_o), 32'd1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("mid_reset_psel", 32'(psel_o), 32'd0);
      chk("mid_reset_penable", 32'(penable_o), 32'd0);
      chk("mid_reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
      q.delete();
      model_reset();
      stuck = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      base = rsp_cnt;
      issue(1'b1, 4'h9, 32'hCAFE_F00D, 1, 1'b0);
      issue(1'b0, 4'h9, 32'h0, 0, 1'b0);
      drain();
      chk("post_reset_rsp_count", 32'(rsp_cnt - base), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/apb_master.md
# apb_master

APB requester that drives the team's APB slave register file. Accepts single read/write commands on a valid/ready request port and runs each as a standard two-phase APB transfer (SETUP, then ACCESS held until `pready_i`). Returns one response pulse per transfer, carrying read data and an optional timeout error. Sits directly upstream of the APB slave, between it and any command source: CPU shim, test sequencer or bridge.

## Interface
Parameters:
- `ADDR_W`, 4: APB address width; matches the slave's 16-entry map.
- `DATA_W`, 32: APB data width.
- `TIMEOUT_CYC`, 15: maximum ACCESS-phase wait cycles with `pready_i` low. Used only when `APB_MASTER_TIMEOUT_EN` is defined. Legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid_i`  in  1  command present.
- `cmd_ready_o`  out  1  command accepted on any edge where `cmd_valid_i && cmd_ready_o`.
- `cmd_write_i`  in  1  1 = write, 0 = read.
- `cmd_addr_i`  in  ADDR_W  target address.
- `cmd_wdata_i`  in  DATA_W  write data; ignored for reads.
- `rsp_valid_o`  out  1  one-cycle completion pulse; no backpressure.
- `rsp_rdata_o`  out  DATA_W  read data; valid with `rsp_valid_o` on reads.
- `rsp_err_o`  out  1  transfer timed out; valid with `rsp_valid_o`.
- `psel_o`, `penable_o`, `pwrite_o`  out  1  APB control signals.
- `paddr_o`  out  ADDR_W  APB address.
- `pwdata_o`  out  DATA_W  APB write data.
- `prdata_i`  in  DATA_W  APB read data.
- `pready_i`  in  1  APB slave ready.

## Operation
- FSM states: IDLE, SETUP, ACCESS. All APB and response outputs are registered.
- **Reset:** state = IDLE. Every output is 0: `cmd_ready_o`, `psel_o`, `penable_o`, `pwrite_o`, `paddr_o`, `pwdata_o`, `rsp_valid_o`, `rsp_rdata_o`, `rsp_err_o`. The wait counter is also 0.
- **IDLE:** `cmd_ready_o` = 1, `psel_o` = `penable_o` = 0.
  - On accept: capture `cmd_write_i` into `pwrite_o` and `cmd_addr_i` into `paddr_o`.
  - Capture `cmd_wdata_i` into `pwdata_o` on writes only; reads leave `pwdata_o` unchanged.
  - Then go to SETUP.
- **SETUP:** `psel_o` = 1, `penable_o` = 0, `cmd_ready_o` = 0. Unconditionally go to ACCESS next cycle.
- **ACCESS:** `psel_o` = 1, `penable_o` = 1. `paddr_o`, `pwrite_o` and `pwdata_o` are held stable.
  - On an edge with `pready_i` = 1, the transfer completes:
    - Reads capture `prdata_i` into `rsp_rdata_o`; writes leave `rsp_rdata_o` unchanged.
    - `rsp_valid_o` = 1 for exactly the next cycle, with `rsp_err_o` = 0.
    - Go to IDLE; `psel_o` and `penable_o` drop in that same cycle.
  - While `pready_i` = 0, stay in ACCESS.
- `pready_i` is ignored outside ACCESS. A high `pready_i` during SETUP does not shorten the transfer.
- `cmd_valid_i` is ignored outside IDLE. Commands are never queued.
- `rsp_valid_o` is never high for two consecutive cycles.

## Timing
- Minimum transfer, with `pready_i` high on the first ACCESS edge:
  - Accept edge at cycle 0.
  - SETUP during cycle 1.
  - ACCESS during cycle 2.
  - `rsp_valid_o` and IDLE (`cmd_ready_o` = 1) during cycle 3.
- Best-case throughput: one command every 3 cycles. The response cycle coincides with the next accept opportunity.
- Each `pready_i` = 0 edge in ACCESS adds exactly one cycle.
- Reset asserted mid-transfer: outputs go to reset values immediately (asynchronously). The in-flight command is dropped and no response is issued.

## Configuration
- `APB_MASTER_TIMEOUT_EN` defined:
  - An 8-bit wait counter clears on entry to ACCESS and increments on each ACCESS edge with `pready_i` = 0.
  - On the edge where the counter equals `TIMEOUT_CYC` and `pready_i` = 0, the transfer aborts: go to IDLE, then `rsp_valid_o` = 1, `rsp_err_o` = 1, `rsp_rdata_o` = 0.
  - `pready_i` = 1 on that same edge takes priority and completes the transfer normally.
- Not defined: no counter is built, ACCESS waits indefinitely, and `rsp_err_o` is constant 0.

## Test plan
- **Reset values:** `rst` = 0 for 2 cycles → all outputs 0. Release `rst` → `cmd_ready_o` = 1 on the next cycle.
- **Zero-wait write:** write `addr` = 4'h5, `wdata` = 32'hDEADBEEF with `pready_i` tied 1.
  - `psel_o` = 1, `penable_o` = 0 for 1 cycle, then `penable_o` = 1 for 1 cycle, with `paddr_o` = 5 and `pwdata_o` = DEADBEEF.
  - `rsp_valid_o` pulses at cycle 3 with `rsp_err_o` = 0.
- **Wait-state read:** read `addr` = 4'hA, `pready_i` low for the first 3 ACCESS cycles, `prdata_i` = 32'h12345678.
  - ACCESS lasts 4 cycles, with `paddr_o` and `pwrite_o` stable throughout.
  - `rsp_rdata_o` = 12345678 with a single `rsp_valid_o` pulse.
- **Back-to-back:** `cmd_valid_i` held high across 16 random writes, then 16 reads of the same addresses, against the APB slave.
  - Every read returns the last data written to that address.
  - Exactly 32 `rsp_valid_o` pulses.
- **Timeout (macro on, `TIMEOUT_CYC` = 15):** `pready_i` stuck 0 → abort after 15 wait cycles with `rsp_err_o` = 1 and `rsp_rdata_o` = 0. With the macro off, `psel_o` stays 1 for 100+ cycles.
- **Reset mid-ACCESS:** assert `rst` during ACCESS → `psel_o` and `penable_o` fall to 0 at once with no `rsp_valid_o`. After release, the next command runs normally.
